eep_spi_resp: RTL

EEP_SPI_RESP -- requirements
Module: eep_spi_resp

---
 rtl/eep_pkg.sv | 14 +
 rtl/spi_sync.sv | 36 +++
 rtl/eep_spi_resp.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/eep_pkg.sv
// Shared constants and FSM state type for the SPI EEPROM emulator.
package eep_pkg;

    localparam int         FRAME_BITS = 16;
    localparam logic [1:0] OP_RD      = 2'b00;
    localparam logic [1:0] OP_WR      = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// One synchronizer chain plus a history flop for rise/fall detection.
// Edges are reported only on synchronized values.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_hist;

    // Shift the raw input through the chain; reset to the line's idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {STAGES{RST_VAL}};
            r_hist  <= RST_VAL;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_hist <= r_chain[STAGES-1];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise =  r_chain[STAGES-1] & ~r_hist;
    assign o_fall = ~r_chain[STAGES-1] &  r_hist;

endmodule

// File: rtl/eep_spi_resp.sv
// SPI mode-0 responder emulating a small byte-wide EEPROM.
// 16-bit frames: {opcode[1:0], addr[5:0], data[7:0]}; read data is returned
// in the low byte of the following frame.
module eep_spi_resp
    import eep_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS_n,
    output logic       MISO,
    output logic       MISO_oe,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] rd_byte
);

    localparam int AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_ss_q,   w_ss_rise,   w_ss_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(SCLK),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_d(MOSI),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .i_d(SS_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_rx, r_tx;
    logic [4:0]         r_bit_cnt;
    logic [7:0]         r_rd_byte;
    logic [7:0]         r_mem [MEM_DEPTH];
    logic [FLUSH_W-1:0] r_flush;
    logic               r_armed;

    logic [6:0]    w_addr_mod;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_op;
    logic          w_start;
    logic          w_unused_sync;

    assign w_op       = r_rx[15:14];
    assign w_addr_mod = {1'b0, r_rx[13:8]} % 7'(MEM_DEPTH);
    assign w_idx      = w_addr_mod[AW-1:0];
    // The synchronizer's reset value fakes "SS_n high"; only a real high seen
    // after the chain has flushed arms frame start.
    assign w_start    = w_ss_fall & r_armed;

    assign w_unused_sync = ^{w_sclk_q, w_mosi_rise, w_mosi_fall, w_addr_mod};

    // Count out the synchronizer flush after reset, then arm once SS_n is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_flush != FLUSH_W'(SYNC_STAGES + 1)) begin
                r_flush <= r_flush + 1'b1;
            end else if (w_ss_q) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        frame_err   = 1'b0;
        case (r_state)
            IDLE:    if (w_start)   w_state_nxt = ACTIVE;
            ACTIVE:  if (w_ss_rise) w_state_nxt = COMMIT;
            COMMIT: begin
                w_state_nxt = IDLE;
                frame_done  = (r_bit_cnt == 5'(FRAME_BITS));
                frame_err   = (r_bit_cnt != 5'(FRAME_BITS));
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift registers, bit counter and read-back byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_rd_byte <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bit_cnt <= '0;
                        r_tx      <= {8'h00, r_rd_byte};
                    end
                end
                ACTIVE: begin
                    // SCLK edges coincident with SS_n rise are dropped.
                    if (!w_ss_rise) begin
                        if (w_sclk_rise) begin
                            r_rx <= {r_rx[14:0], w_mosi_q};
                            if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                        if (w_sclk_fall) begin
                            r_tx <= {r_tx[14:0], 1'b0};
                        end
                    end
                end
                COMMIT: begin
                    if (frame_done && w_op == OP_RD) r_rd_byte <= r_mem[w_idx];
                end
                default: ;
            endcase
        end
    end

    // Memory array: cleared on reset, written only on a committed write frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (frame_done && w_op == OP_WR) begin
            r_mem[w_idx] <= r_rx[7:0];
        end
    end

    assign MISO_oe = ~w_ss_q;
    assign MISO    = MISO_oe & r_tx[15];
    assign rd_byte = r_rd_byte;

endmodule
